// File: rtl/alu_reservation_station_if.sv
// Dispatch, CDB and issue-stage signal bundle for one ALU reservation station.
// master = dispatch/CDB/exec side, slave = the reservation station.
interface alu_reservation_station_if #(
    parameter int ROBsizeLog = 6,
    parameter int CMD_W      = 10
);
    logic                  dispatchValid_i;
    logic                  dispatchReady_o;
    logic [CMD_W-1:0]      dispatchCommands_i;
    logic [ROBsizeLog-1:0] dispatchTag_i;
    logic [63:0]           dispatchVal1_i;
    logic [63:0]           dispatchVal2_i;
    logic [ROBsizeLog-1:0] dispatchSrc1_i;
    logic [ROBsizeLog-1:0] dispatchSrc2_i;
    logic                  dispatchRdy1_i;
    logic                  dispatchRdy2_i;

    logic                  cdbValid_i;
    logic [ROBsizeLog-1:0] cdbTag_i;
    logic [63:0]           cdbValue_i;

    logic                  stallRS_i;
    logic                  readyRS_o;
    logic [63:0]           reservationStationVal1_o;
    logic [63:0]           reservationStationVal2_o;
    logic [CMD_W-1:0]      reservationStationCommands_o;
    logic [ROBsizeLog-1:0] reservationStationTag_o;

    modport master (
        output dispatchValid_i, dispatchCommands_i, dispatchTag_i,
               dispatchVal1_i, dispatchVal2_i, dispatchSrc1_i, dispatchSrc2_i,
               dispatchRdy1_i, dispatchRdy2_i, cdbValid_i, cdbTag_i, cdbValue_i,
               stallRS_i,
        input  dispatchReady_o, readyRS_o, reservationStationVal1_o,
               reservationStationVal2_o, reservationStationCommands_o,
               reservationStationTag_o
    );

    modport slave (
        input  dispatchValid_i, dispatchCommands_i, dispatchTag_i,
               dispatchVal1_i, dispatchVal2_i, dispatchSrc1_i, dispatchSrc2_i,
               dispatchRdy1_i, dispatchRdy2_i, cdbValid_i, cdbTag_i, cdbValue_i,
               stallRS_i,
        output dispatchReady_o, readyRS_o, reservationStationVal1_o,
               reservationStationVal2_o, reservationStationCommands_o,
               reservationStationTag_o
    );
endinterface

// File: rtl/alu_reservation_station.sv
// ALU reservation station: holds ops until both operands arrive, wakes them from the CDB,
// issues the lowest-index ready op. Optional RS_WAKEUP_BYPASS_EN issues straight off the CDB.
module alu_reservation_station #(
    parameter int ROBsize    = 32,
    parameter int ROBsizeLog = $clog2(ROBsize + 1),
    parameter int RS_DEPTH   = 4,
    parameter int CMD_W      = 10,
    parameter int OCC_W      = $clog2(RS_DEPTH + 1)
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic                     flush_i,
    alu_reservation_station_if.slave rsIf,
    output logic [OCC_W-1:0]         occupancy_o
);
    localparam int IDX_W = $clog2(RS_DEPTH);

    logic [RS_DEPTH-1:0]                 valid, rdy1, rdy2;
    logic [RS_DEPTH-1:0][CMD_W-1:0]      cmd;
    logic [RS_DEPTH-1:0][ROBsizeLog-1:0] tag, src1, src2;
    logic [RS_DEPTH-1:0][63:0]           val1, val2;
    logic [OCC_W-1:0]                    occ;

    logic [RS_DEPTH-1:0] hit1, hit2, entryReady, wrEn, clrEn;
    logic [IDX_W-1:0]    freeIdx, selIdx;
    logic                dispFire, issueFire, dispHit1, dispHit2;

    always_comb begin
        hit1       = '0;
        hit2       = '0;
        entryReady = '0;
        for (int i = 0; i < RS_DEPTH; i++) begin
            hit1[i] = rsIf.cdbValid_i & valid[i] & ~rdy1[i] & (src1[i] == rsIf.cdbTag_i);
            hit2[i] = rsIf.cdbValid_i & valid[i] & ~rdy2[i] & (src2[i] == rsIf.cdbTag_i);
`ifdef RS_WAKEUP_BYPASS_EN
            entryReady[i] = valid[i] & (rdy1[i] | hit1[i]) & (rdy2[i] | hit2[i]);
`else
            entryReady[i] = valid[i] & rdy1[i] & rdy2[i];
`endif
        end
    end

    // Descending scan so the lowest index wins.
    always_comb begin
        freeIdx = '0;
        selIdx  = '0;
        for (int i = RS_DEPTH - 1; i >= 0; i--) begin
            if (!valid[i])     freeIdx = IDX_W'(i);
            if (entryReady[i]) selIdx  = IDX_W'(i);
        end
    end

    assign rsIf.dispatchReady_o = (occ < OCC_W'(RS_DEPTH));
    assign rsIf.readyRS_o       = |entryReady;
    assign dispFire  = rsIf.dispatchValid_i & rsIf.dispatchReady_o;
    assign issueFire = rsIf.readyRS_o & ~rsIf.stallRS_i;
    assign dispHit1  = rsIf.cdbValid_i & ~rsIf.dispatchRdy1_i & (rsIf.dispatchSrc1_i == rsIf.cdbTag_i);
    assign dispHit2  = rsIf.cdbValid_i & ~rsIf.dispatchRdy2_i & (rsIf.dispatchSrc2_i == rsIf.cdbTag_i);
    assign occupancy_o = occ;

    always_comb begin
        wrEn  = '0;
        clrEn = '0;
        for (int i = 0; i < RS_DEPTH; i++) begin
            wrEn[i]  = dispFire  & (freeIdx == IDX_W'(i));
            clrEn[i] = issueFire & (selIdx  == IDX_W'(i));
        end
    end

    always_comb begin
        rsIf.reservationStationVal1_o     = '0;
        rsIf.reservationStationVal2_o     = '0;
        rsIf.reservationStationCommands_o = '0;
        rsIf.reservationStationTag_o      = '0;
        if (rsIf.readyRS_o) begin
            rsIf.reservationStationVal1_o     = val1[selIdx];
            rsIf.reservationStationVal2_o     = val2[selIdx];
            rsIf.reservationStationCommands_o = cmd[selIdx];
            rsIf.reservationStationTag_o      = tag[selIdx];
`ifdef RS_WAKEUP_BYPASS_EN
            if (!rdy1[selIdx]) rsIf.reservationStationVal1_o = rsIf.cdbValue_i;
            if (!rdy2[selIdx]) rsIf.reservationStationVal2_o = rsIf.cdbValue_i;
`endif
        end
    end

    // The free slot comes from registered valid bits, so a slot issued this cycle is never reused.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            valid <= '0;
            rdy1  <= '0;
            rdy2  <= '0;
            cmd   <= '0;
            tag   <= '0;
            src1  <= '0;
            src2  <= '0;
            val1  <= '0;
            val2  <= '0;
            occ   <= '0;
        end else if (flush_i) begin
            valid <= '0;
            occ   <= '0;
        end else begin
            occ <= occ + OCC_W'(dispFire) - OCC_W'(issueFire);
            for (int i = 0; i < RS_DEPTH; i++) begin
                if (wrEn[i]) begin
                    valid[i] <= 1'b1;
                    cmd[i]   <= rsIf.dispatchCommands_i;
                    tag[i]   <= rsIf.dispatchTag_i;
                    src1[i]  <= rsIf.dispatchSrc1_i;
                    src2[i]  <= rsIf.dispatchSrc2_i;
                    rdy1[i]  <= rsIf.dispatchRdy1_i | dispHit1;
                    rdy2[i]  <= rsIf.dispatchRdy2_i | dispHit2;
                    val1[i]  <= dispHit1 ? rsIf.cdbValue_i : rsIf.dispatchVal1_i;
                    val2[i]  <= dispHit2 ? rsIf.cdbValue_i : rsIf.dispatchVal2_i;
                end else begin
                    if (clrEn[i]) valid[i] <= 1'b0;
                    if (hit1[i]) begin
                        rdy1[i] <= 1'b1;
                        val1[i] <= rsIf.cdbValue_i;
                    end
                    if (hit2[i]) begin
                        rdy2[i] <= 1'b1;
                        val2[i] <= rsIf.cdbValue_i;
                    end
                end
            end
        end
    end
endmodule
